// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC / IF-ID enables, operand forwarding
// muxes, the ID/EX control and operand registers, the EX->MEM destination
// register and a saturating counter of inserted bubbles.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        forward1_EX,
  input  logic        forward2_EX,
  input  logic        forward1_MEM,
  input  logic        forward2_MEM,
  input  logic        flush,
  input  logic        ID_reg_write,
  input  logic        ID_memread,
  input  logic [4:0]  ID_write_reg_addr,
  input  logic [31:0] ID_rs_data,
  input  logic [31:0] ID_rt_data,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] MEM_result,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        EX_memread,
  output logic [4:0]  EX_write_reg_addr,
  output logic [4:0]  MEM_write_reg_addr,
  output logic [31:0] EX_opnd1,
  output logic [31:0] EX_opnd2,
  output logic [15:0] bubble_cnt
);

  logic        ex_memread_q, ex_memread_d;
  logic [4:0]  ex_waddr_q, ex_waddr_d;
  logic [4:0]  mem_waddr_q, mem_waddr_d;
  logic [31:0] ex_opnd1_q, ex_opnd1_d;
  logic [31:0] ex_opnd2_q, ex_opnd2_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic        bubble;
  logic [31:0] opnd1_sel;
  logic [31:0] opnd2_sel;

  // A flush overrides a stall, so the front end keeps advancing on a flush.
  assign bubble      = stall | flush;
  assign pc_write    = ~stall | flush;
  assign if_id_write = ~stall | flush;
  assign if_id_flush = flush;

  // Forwarding muxes: the EX result is the most recent producer and wins.
  always_comb begin
    opnd1_sel = ID_rs_data;
    opnd2_sel = ID_rt_data;
    if (forward1_EX)       opnd1_sel = EX_alu_result;
    else if (forward1_MEM) opnd1_sel = MEM_result;
    if (forward2_EX)       opnd2_sel = EX_alu_result;
    else if (forward2_MEM) opnd2_sel = MEM_result;
  end

  // Next-state for the ID/EX stage, the MEM destination and the bubble counter.
  always_comb begin
    ex_memread_d = 1'b0;
    ex_waddr_d   = 5'd0;
    ex_opnd1_d   = 32'd0;
    ex_opnd2_d   = 32'd0;
    mem_waddr_d  = ex_waddr_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bubble) begin
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      ex_memread_d = ID_memread & ID_reg_write;
      // Address 0 passes through as 0, so $0 never looks like a producer.
      ex_waddr_d   = ID_reg_write ? ID_write_reg_addr : 5'd0;
      ex_opnd1_d   = opnd1_sel;
      ex_opnd2_d   = opnd2_sel;
    end
  end

  // State registers with synchronous reset overriding stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_memread_q <= 1'b0;
      ex_waddr_q   <= 5'd0;
      mem_waddr_q  <= 5'd0;
      ex_opnd1_q   <= 32'd0;
      ex_opnd2_q   <= 32'd0;
      bubble_cnt_q <= 16'd0;
    end else begin
      ex_memread_q <= ex_memread_d;
      ex_waddr_q   <= ex_waddr_d;
      mem_waddr_q  <= mem_waddr_d;
      ex_opnd1_q   <= ex_opnd1_d;
      ex_opnd2_q   <= ex_opnd2_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EX_memread         = ex_memread_q;
  assign EX_write_reg_addr  = ex_waddr_q;
  assign MEM_write_reg_addr = mem_waddr_q;
  assign EX_opnd1           = ex_opnd1_q;
  assign EX_opnd2           = ex_opnd2_q;
  assign bubble_cnt         = bubble_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have the following inputs (name  direction  width  meaning):
- stall  in  1  load-use stall request from hazard unit
- forward1_EX  in  1  operand 1 takes EX-stage result
- forward2_EX  in  1  operand 2 takes EX-stage result
- forward1_MEM  in  1  operand 1 takes MEM-stage result
- forward2_MEM  in  1  operand 2 takes MEM-stage result
- flush  in  1  taken branch/jump; squash ID instruction
- ID_reg_write  in  1  ID instruction writes a register
- ID_memread  in  1  ID instruction is a load
- ID_write_reg_addr  in  5  ID destination register
- ID_rs_data  in  32  register-file read data, port 1
- ID_rt_data  in  32  register-file read data, port 2
- EX_alu_result  in  32  combinational result of the EX instruction
- MEM_result  in  32  ALU or load data of the MEM instruction
REQ-003 SHALL have the following outputs (name  direction  width  meaning):
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register update enable
- if_id_flush  out  1  clear IF/ID register
- EX_memread  out  1  registered; EX instruction is a load
- EX_write_reg_addr  out  5  registered EX destination; 0 = no write
- MEM_write_reg_addr  out  5  registered MEM destination; 0 = no write
- EX_opnd1  out  32  registered operand 1 for EX
- EX_opnd2  out  32  registered operand 2 for EX
- bubble_cnt  out  16  saturating count of inserted bubbles

Function
REQ-004 SHALL drive pc_write = if_id_write = (~stall | flush) combinationally.
REQ-005 SHALL drive if_id_flush = flush combinationally.
REQ-006 SHALL select operand 1 as EX_alu_result if forward1_EX=1; else MEM_result if forward1_MEM=1; else ID_rs_data. EX has priority when both are set (most recent producer).
REQ-007 SHALL select operand 2 by the same rule using forward2_EX, forward2_MEM and ID_rt_data.
REQ-008 SHALL, on each clk edge with rst=0, stall=0 and flush=0, load:
- EX_opnd1/EX_opnd2 <= selected operands
- EX_memread <= ID_memread & ID_reg_write
- EX_write_reg_addr <= ID_reg_write ? ID_write_reg_addr : 0
REQ-009 SHALL, on a clk edge with stall=1 or flush=1, insert a bubble: EX_memread<=0, EX_write_reg_addr<=0, EX_opnd1<=0, EX_opnd2<=0.
REQ-010 SHALL update MEM_write_reg_addr <= EX_write_reg_addr on every non-reset edge, regardless of stall or flush.
REQ-011 SHALL increment bubble_cnt by 1 on every edge where REQ-009 applies. The count saturates at 16'hFFFF and does not wrap.
REQ-012 SHALL give flush priority when stall and flush are both 1: bubble inserted, pc_write=1, if_id_flush=1, bubble_cnt incremented once.
REQ-013 SHALL hold EX_write_reg_addr at 0 for ID_write_reg_addr=0 even when ID_reg_write=1, so register $0 never triggers forwarding.
REQ-014 SHALL enforce a load-use latency of exactly one bubble: the cycle after the bubble, the load sits in MEM and its data reaches the consumer through the MEM forward path.

Reset
REQ-015 SHALL, on a clk edge with rst=1, clear EX_memread, EX_write_reg_addr, MEM_write_reg_addr, EX_opnd1, EX_opnd2 and bubble_cnt to 0, overriding stall and flush.
REQ-016 SHALL keep pc_write and if_id_write combinational during reset (1 unless stall=1 and flush=0).
REQ-017 SHALL abandon any in-flight stall or forwarding state when reset is asserted mid-operation; the first post-reset edge behaves per REQ-008/009.

Verification
REQ-018 Bench SHALL cover the following directed scenarios:
- No hazard: ID_rs_data=5, ID_rt_data=7, no forwards, ID_reg_write=1, addr=3 -> next edge EX_opnd1=5, EX_opnd2=7, EX_write_reg_addr=3; following edge MEM_write_reg_addr=3.
- Double forward: forward1_EX=1, forward1_MEM=1, EX_alu_result=0xAA, MEM_result=0xBB -> EX_opnd1=0xAA; with forward2_MEM=1 only -> EX_opnd2=0xBB.
- Load-use: stall=1 for one cycle -> pc_write=0, if_id_write=0, next edge EX_write_reg_addr=0, EX_memread=0, bubble_cnt=1; prior EX addr appears in MEM_write_reg_addr.
- Stall+flush: both 1 -> pc_write=1, if_id_flush=1, bubble inserted, bubble_cnt +1 only.
- Saturation: preload 65534 bubbles, then 3 more stall cycles -> bubble_cnt=0xFFFF.
- Reset mid-stall: rst=1 while stall=1 with EX_write_reg_addr=9 -> all registered outputs 0 after the edge.
